// File: rtl/rsq_pkg.sv
// rsq register bank shared definitions.
// Conflict-priority encodings and the pulse counter width helper.
package rsq_pkg;

    // Which request wins when set and clear hit the same bit together.
    localparam bit PRIO_CLR = 1'b0;
    localparam bit PRIO_SET = 1'b1;

    // Pulse counter width: enough bits to hold MIN_PULSE.
    function automatic int cnt_w(input int min_pulse);
        if (min_pulse < 1)
            return 1;
        return $clog2(min_pulse + 1);
    endfunction

endpackage

// File: rtl/rsq_pulse_checker.sv
// One-bit minimum-pulse-width checker with a sticky violation flag.
// Ports: CLK, RN (async low), req, viol_clr -> viol.
module rsq_pulse_checker #(
    parameter int MIN_PULSE = 2
) (
    input  logic CLK,
    input  logic RN,
    input  logic req,
    input  logic viol_clr,
    output logic viol
);
    import rsq_pkg::*;

    localparam int CW = cnt_w(MIN_PULSE);
    localparam logic [CW-1:0] CMAX = CW'(MIN_PULSE);

    logic [CW-1:0] cnt;
    logic          armed;
    logic          short_fall;

    // cnt is non-zero only while a checked request was asserted
    // on the previous edge, so this is a 1->0 edge of a short pulse.
    assign short_fall = !req && (cnt != '0) && (cnt < CMAX);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt   <= '0;
            armed <= 1'b0;
            viol  <= 1'b0;
        end else begin
            // A request already in flight at reset release is not
            // measured; checking starts after an idle sample.
            armed <= armed | ~req;
            if (req && armed) begin
                if (cnt != CMAX)
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            // A fresh violation beats a simultaneous clear.
            if (short_fall)
                viol <= 1'b1;
            else if (viol_clr)
                viol <= 1'b0;
        end
    end

endmodule

// File: rtl/rsq_register_bank.sv
// WIDTH-bit register bank with per-bit set/clear, load enable,
// change pulse (CHG) and short-pulse violation flags (VIOL).
module rsq_register_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               PRIO_SET  = rsq_pkg::PRIO_CLR,
    parameter int               MIN_PULSE = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] RNV,
    input  logic [WIDTH-1:0] SETNV,
    input  logic             VIOL_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             CHG,
    output logic [WIDTH-1:0] VIOL
);
    import rsq_pkg::*;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] req;

    assign req = ~RNV | ~SETNV;

    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (1'b1)
                (!RNV[i] && !SETNV[i]): q_next[i] = PRIO_SET;
                (!RNV[i] &&  SETNV[i]): q_next[i] = 1'b0;
                ( RNV[i] && !SETNV[i]): q_next[i] = 1'b1;
                default:                q_next[i] = E ? D[i] : Q[i];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            Q   <= RESET_VAL;
            CHG <= 1'b0;
        end else begin
            Q   <= q_next;
            CHG <= (q_next != Q);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chk
        rsq_pulse_checker #(
            .MIN_PULSE(MIN_PULSE)
        ) u_chk (
            .CLK     (CLK),
            .RN      (RN),
            .req     (req[i]),
            .viol_clr(VIOL_CLR),
            .viol    (VIOL[i])
        );
    end

endmodule

// File: doc/rsq_register_bank.md
Name: rsq_register_bank

Overview:
- WIDTH-bit clocked register bank, the parametrised successor of the single-bit set/reset latch.
- Each bit has:
  - a shared load enable (E/D),
  - an active-low clear request and an active-low set request,
  - a configurable set-vs-clear priority,
  - a minimum-pulse-width checker that flags short set/clear requests.
- Sits between control/status logic and the consumers of static configuration bits.
- Provides a change-notify pulse for downstream interrupt logic.

Parameters:
- WIDTH, 8, number of register bits (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q by the global reset.
- PRIO_SET, 0, per-bit conflict resolution: 0 = clear wins, 1 = set wins.
- MIN_PULSE, 2, minimum number of consecutive cycles a set/clear request must stay asserted (>=1; 1 disables checking).

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low global reset.
- E  input  1  load enable: Q <= D when no per-bit request is active.
- D  input  WIDTH  load data.
- RNV  input  WIDTH  per-bit active-low synchronous clear request.
- SETNV  input  WIDTH  per-bit active-low synchronous set request.
- VIOL_CLR  input  1  clears all VIOL bits.
- Q  output  WIDTH  register contents.
- CHG  output  1  one-cycle pulse: Q changed on the last edge.
- VIOL  output  WIDTH  sticky per-bit short-pulse violation flags.

Behaviour:
- Interface: one clock, CLK. Reset RN is asynchronous, active-low.
- While RN=0:
  - Q=RESET_VAL, CHG=0, VIOL=0.
  - All pulse counters are 0.
- RN release: the first update occurs at the first CLK rise with RN=1.
- Per-bit next-state priority, evaluated at each CLK rise; Q updates with 1-cycle latency:
  1. RNV[i]=0 and SETNV[i]=0: Q[i] <= PRIO_SET.
  2. RNV[i]=0 only: Q[i] <= 0.
  3. SETNV[i]=0 only: Q[i] <= 1.
  4. Otherwise, E=1: Q[i] <= D[i].
  5. Otherwise: hold.
- Per-bit requests always override E. Bits without a request still load D when E=1 in the same cycle.
- CHG is registered: CHG <= (q_next != Q). It is high exactly in the cycle Q shows a new value. Reloading an identical value does not assert CHG.
- Pulse checker, per bit:
  - req[i] = ~RNV[i] | ~SETNV[i].
  - cnt[i] counts consecutive asserted cycles and saturates at MIN_PULSE. Width is clog2(MIN_PULSE+1).
  - When req[i] falls (sampled 1 then 0) with cnt[i] < MIN_PULSE: VIOL[i] <= 1. The counter returns to 0 on deassertion.
  - The violating request still takes effect. Checking is advisory only.
  - A request switching from clear to set with no idle cycle counts as one continuous pulse.
- VIOL:
  - Sticky until VIOL_CLR=1 at a clock edge.
  - A new violation in the same cycle as VIOL_CLR wins: that bit stays/gets set; other bits clear.
- Reset mid-pulse: counters are cleared, so no violation is flagged for a request already in progress when RN rose. Checking begins on the next fresh assertion.
- MIN_PULSE=1: VIOL is constant 0.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package rsq_pkg:
  - PRIO_CLR/PRIO_SET constants.
  - Counter-width function (clog2 of MIN_PULSE+1).
- Natural sub-module rsq_pulse_checker: one bit of counter + VIOL flag. Parameter MIN_PULSE; ports CLK, RN, req, viol_clr, viol. WIDTH instances are generated.
- Bit datapath and CHG stay in the top.

Test Plan:
(all WIDTH=8, MIN_PULSE=2, PRIO_SET=0, RESET_VAL=8'h00 unless noted)
1. Async reset: hold RN=0 mid-cycle with E=1, D=8'hFF. Q=8'h00, CHG=0, VIOL=0 immediately, without a clock edge. Release RN; the next edge gives Q=8'hFF, CHG=1 for one cycle.
2. Priority mix: Q=8'h0F; drive E=1, D=8'hAA, RNV=8'hFE, SETNV=8'h7F for 2 cycles. After the first edge, Q=8'hAA with bit0=0 and bit7=1, i.e. 8'hAA. Then D=8'h55 with the same requests gives Q=8'hD4. CHG pulses at each change only.
3. Conflict: RNV[3]=0 and SETNV[3]=0 for 2 cycles.
   - PRIO_SET=0: Q[3]=0.
   - Rerun with PRIO_SET=1: Q[3]=1.
   - VIOL[3] stays 0 in both runs.
4. Short pulse: SETNV[5]=0 for exactly 1 cycle. Q[5]=1 after that edge, and VIOL[5]=1 one edge after deassertion. A 2-cycle pulse on bit 6 gives VIOL[6]=0.
5. Clear race: VIOL=8'h20; assert VIOL_CLR in the same cycle a 1-cycle RNV[1] pulse ends. The result is VIOL=8'h02.
6. Reset mid-pulse: assert RNV[2]=0, pulse RN low after 1 cycle, release, hold RNV[2]=0 for 1 more cycle. VIOL[2]=0 and Q[2]=0.
